// File: rtl/rom_upload_bridge.sv
// Packs ioctl download bytes into 16-bit words, queues them in a small FIFO and
// writes each one to SDRAM port1 using the toggle req/ack handshake.
`timescale 1ns/1ps
module rom_upload_bridge #(
  parameter int FIFO_AW = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        busy,
  output logic        rom_loaded,
  output logic        overflow
);

  localparam int EW    = 41;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {IDLE, WAIT} state_t;

  logic               wr_d_q, dl_d_q;
  logic               pend_valid_q, pend_valid_d;
  logic [22:0]        pend_wa_q, pend_wa_d;
  logic               pend_lane_q, pend_lane_d;
  logic [7:0]         pend_byte_q, pend_byte_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  state_t             state_q, state_d;
  logic               req_q, req_d, we_q, we_d;
  logic [22:0]        a_q, a_d;
  logic [1:0]         ds_q, ds_d;
  logic [15:0]        d_q, d_d;
  logic               rom_loaded_q, rom_loaded_d;
  logic               seen_dl_q, seen_dl_d;
  logic               overflow_q, overflow_d;

  logic               stb, dl_rise, dl_fall;
  logic               push, pop, full, empty;
  logic [EW-1:0]      push_data, pend_entry, head;
  logic               unused_addr_msb;

  assign unused_addr_msb = ioctl_addr[24];

  assign stb     = ioctl_wr & ~wr_d_q;
  assign dl_rise = ioctl_download & ~dl_d_q;
  assign dl_fall = ~ioctl_download & dl_d_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign head  = mem_q[rptr_q[FIFO_AW-1:0]];

  // A lone pending byte is emitted on its own lane with the other lane zeroed.
  assign pend_entry = pend_lane_q ? {pend_wa_q, 2'b10, pend_byte_q, 8'h00}
                                  : {pend_wa_q, 2'b01, 8'h00, pend_byte_q};

  always_comb begin
    push         = 1'b0;
    push_data    = '0;
    pend_valid_d = pend_valid_q;
    pend_wa_d    = pend_wa_q;
    pend_lane_d  = pend_lane_q;
    pend_byte_d  = pend_byte_q;
    if (stb) begin
      if (ioctl_addr[0] && pend_valid_q && !pend_lane_q &&
          (pend_wa_q == ioctl_addr[23:1])) begin
        push         = 1'b1;
        push_data    = {pend_wa_q, 2'b11, ioctl_dout, pend_byte_q};
        pend_valid_d = 1'b0;
      end else begin
        push         = pend_valid_q;
        push_data    = pend_entry;
        pend_valid_d = 1'b1;
        pend_wa_d    = ioctl_addr[23:1];
        pend_lane_d  = ioctl_addr[0];
        pend_byte_d  = ioctl_dout;
      end
    end else if (pend_valid_q && (pend_lane_q || dl_fall)) begin
      push         = 1'b1;
      push_data    = pend_entry;
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    ds_d    = ds_q;
    d_d     = d_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          {a_d, ds_d, d_d} = head;
          pop     = 1'b1;
          we_d    = 1'b1;
          req_d   = ~req_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (port1_ack == req_q) begin
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wptr_d = wptr_q + ((push && !full) ? (FIFO_AW+1)'(1) : '0);
  assign rptr_d = rptr_q + (pop ? (FIFO_AW+1)'(1) : '0);

  always_comb begin
    seen_dl_d    = seen_dl_q | dl_rise;
    overflow_d   = overflow_q;
    rom_loaded_d = rom_loaded_q;
    if (dl_rise) begin
      overflow_d   = 1'b0;
      rom_loaded_d = 1'b0;
    end else begin
      if (push && full)
        overflow_d = 1'b1;
      if (!ioctl_download && !pend_valid_q && empty && (state_q == IDLE) && seen_dl_q)
        rom_loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push && !full)
      mem_q[wptr_q[FIFO_AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_d_q       <= 1'b0;
      dl_d_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_wa_q    <= '0;
      pend_lane_q  <= 1'b0;
      pend_byte_q  <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      a_q          <= '0;
      ds_q         <= '0;
      d_q          <= '0;
      rom_loaded_q <= 1'b0;
      seen_dl_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_d_q       <= ioctl_wr;
      dl_d_q       <= ioctl_download;
      pend_valid_q <= pend_valid_d;
      pend_wa_q    <= pend_wa_d;
      pend_lane_q  <= pend_lane_d;
      pend_byte_q  <= pend_byte_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      a_q          <= a_d;
      ds_q         <= ds_d;
      d_q          <= d_d;
      rom_loaded_q <= rom_loaded_d;
      seen_dl_q    <= seen_dl_d;
      overflow_q   <= overflow_d;
    end
  end

  assign port1_req  = req_q;
  assign port1_we   = we_q;
  assign port1_a    = a_q;
  assign port1_ds   = ds_q;
  assign port1_d    = d_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;
  assign busy       = ioctl_download | pend_valid_q | ~empty | (state_q == WAIT);

endmodule

// File: tb/tb_rom_upload_bridge.sv
// Scoreboard bench for rom_upload_bridge: expected SDRAM writes are queued as bytes
// are driven; a negedge monitor pops and compares on every port1_req toggle.
`timescale 1ns/1ps
module tb_rom_upload_bridge;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port1_we;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        busy, rom_loaded, overflow;

  rom_upload_bridge #(.FIFO_AW(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_we(port1_we), .port1_d(port1_d),
    .busy(busy), .rom_loaded(rom_loaded), .overflow(overflow)
  );

  always #10 clk_sys = ~clk_sys;

  int          tests_run = 0, tests_failed = 0;
  logic [40:0] exp_q[$];
  logic [40:0] exp_e;
  int          hold_ack = 0, ack_dly = 3, ack_cnt = 0;
  logic        last_req = 1'b0;
  int          n_issued = 0;
  logic        early_flag = 1'b0, busy_flag = 1'b0;

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // SDRAM model: answers each request ack_dly negedges later unless held.
  initial begin
    port1_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        port1_ack = 1'b0;
        ack_cnt   = 0;
      end else if (hold_ack == 0 && port1_req !== port1_ack) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          port1_ack = port1_req;
          ack_cnt   = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        last_req = 1'b0;
      end else begin
        if (port1_req !== last_req) begin
          last_req = port1_req;
          n_issued++;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_write: got a=%h ds=%b d=%h, required no write",
                     port1_a, port1_ds, port1_d);
          end else begin
            exp_e = exp_q.pop_front();
            $display("[TB] write a=%h ds=%b d=%h expected a=%h ds=%b d=%h",
                     port1_a, port1_ds, port1_d, exp_e[40:18], exp_e[17:16], exp_e[15:0]);
            check("write_entry", {port1_a, port1_ds, port1_d}, exp_e);
            check("we_on_issue", 41'(port1_we), 41'd1);
          end
        end
        if (rom_loaded && (exp_q.size() != 0 || port1_req !== port1_ack)) early_flag = 1'b1;
        if (rom_loaded && busy) busy_flag = 1'b1;
      end
    end
  end

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic expect_wr(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    exp_q.push_back({a, ds, d});
  endtask

  task automatic dl_start();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("rom_loaded_cleared", 41'(rom_loaded), 41'd0);
    check("overflow_cleared", 41'(overflow), 41'd0);
    check("busy_in_download", 41'(busy), 41'd1);
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!(rom_loaded === 1'b1 && exp_q.size() == 0) && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    tests_run++;
    if (!(rom_loaded === 1'b1 && exp_q.size() == 0)) begin
      tests_failed++;
      $display("FAIL %s_done: rom_loaded=%b pending=%0d, required rom_loaded=1 pending=0",
               name, rom_loaded, exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    int base;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    #1;
    check("reset_req", 41'(port1_req), 41'd0);
    check("reset_we", 41'(port1_we), 41'd0);
    check("reset_out", {port1_a, port1_ds, port1_d}, 41'd0);
    check("reset_flags", {39'd0, rom_loaded, overflow}, 41'd0);
    check("reset_busy", 41'(busy), 41'd0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // 1: byte pair packs into one word, issued one cycle after the push
    dl_start();
    expect_wr(23'd0, 2'b11, 16'h2211);
    wr_byte(25'd0, 8'h11);
    wr_byte(25'd1, 8'h22);
    check("issue_latency_req", 41'(port1_req), 41'd1);
    dl_end();
    wait_done("pair", 200);
    check("ack_returns_idle", {39'd0, port1_ack, port1_we}, 41'b10);

    // 2: odd-only byte and even byte flushed by download end
    dl_start();
    expect_wr(23'd2, 2'b10, 16'h3300);
    wr_byte(25'd5, 8'h33);
    expect_wr(23'd4, 2'b01, 16'h0044);
    wr_byte(25'd8, 8'h44);
    dl_end();
    wait_done("single", 200);

    // 3: non-consecutive bytes stay separate byte writes
    dl_start();
    expect_wr(23'd1, 2'b01, 16'h00AA);
    expect_wr(23'd3, 2'b10, 16'hBB00);
    wr_byte(25'd2, 8'hAA);
    wr_byte(25'd7, 8'hBB);
    dl_end();
    wait_done("nonconsec", 200);

    // 4: ack stalled: one write in flight plus 8 queued, the rest dropped
    hold_ack = 1;
    base = n_issued;
    dl_start();
    for (int i = 0; i < 20; i++) begin
      if (i <= 8) expect_wr(23'(i), 2'b11, {8'(2*i+1) | 8'h80, 8'(2*i)});
      wr_byte(25'(2*i), 8'(2*i));
      wr_byte(25'(2*i+1), 8'(2*i+1) | 8'h80);
    end
    check("overflow_set", 41'(overflow), 41'd1);
    hold_ack = 0;
    dl_end();
    wait_done("overflow", 500);
    check("overflow_write_count", 41'(n_issued - base), 41'd9);
    check("overflow_sticky", 41'(overflow), 41'd1);

    // 5: streamed download, ack after 3 cycles
    base = n_issued;
    early_flag = 1'b0;
    busy_flag  = 1'b0;
    dl_start();
    for (int i = 0; i < 1024; i++) begin
      expect_wr(23'(i), 2'b11, {8'(i >> 2) ^ 8'h5C, 8'(i)});
      wr_byte(25'(2*i), 8'(i));
      wr_byte(25'(2*i+1), 8'(i >> 2) ^ 8'h5C);
    end
    dl_end();
    wait_done("stream", 20000);
    check("stream_write_count", 41'(n_issued - base), 41'd1024);
    check("stream_no_overflow", 41'(overflow), 41'd0);
    check("stream_not_busy", 41'(busy), 41'd0);
    check("rom_loaded_not_early", 41'(early_flag), 41'd0);
    check("busy_low_when_loaded", 41'(busy_flag), 41'd0);

    // 6: reset while a write is outstanding
    hold_ack = 1;
    dl_start();
    expect_wr(23'd5, 2'b11, 16'hC1C0);
    wr_byte(25'd10, 8'hC0);
    wr_byte(25'd11, 8'hC1);
    check("wait_we", 41'(port1_we), 41'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_req_we", {39'd0, port1_req, port1_we}, 41'd0);
    check("midreset_out", {port1_a, port1_ds, port1_d}, 41'd0);
    check("midreset_flags", {39'd0, rom_loaded, overflow}, 41'd0);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    hold_ack = 0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    dl_start();
    expect_wr(23'd0, 2'b11, 16'hA55A);
    wr_byte(25'd0, 8'h5A);
    wr_byte(25'd1, 8'hA5);
    dl_end();
    wait_done("after_reset", 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
